// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift ops
// plus iterative unsigned multiply (shift-add) and restoring divide.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH),
    localparam int CW  = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outport,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     rem_q;
    logic [2*WIDTH-1:0]   acc_q;

    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        dif;
    logic [WIDTH-1:0]        sc_res;
    logic                    sc_ov;
    logic                    is_mul;
    logic                    is_div;
    logic                    accept;
    logic                    last;

    logic [2*WIDTH-1:0]   acc_nx;
    logic [WIDTH:0]       r_sh;
    logic [WIDTH:0]       r_dif;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign negative = outport[WIDTH-1];
    assign zero     = (outport == '0);

    assign shamt  = porta[SHW-1:0];
    assign a_s    = porta;
    assign b_s    = portb;
    assign sum    = porta + portb;
    assign dif    = porta - portb;
    assign is_mul = (aluop == 4'd11) || (aluop == 4'd12);
    assign is_div = (aluop == 4'd13) || (aluop == 4'd14);
    assign last   = (cnt == CNT_ONE);

    // MSB-first shift-add: acc = 2*acc + bit*A
    assign acc_nx = {acc_q[2*WIDTH-2:0], 1'b0}
                  + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);

    // Restoring step; a_q shifts dividend bits out and quotient bits in.
    // A zero divisor never borrows, giving all-ones quotient and remainder A.
    assign r_sh   = {rem_q, a_q[WIDTH-1]};
    assign r_dif  = r_sh - {1'b0, b_q};
    assign rem_nx = r_dif[WIDTH] ? r_sh[WIDTH-1:0] : r_dif[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], ~r_dif[WIDTH]};

    always_comb begin
        sc_res = '0;
        sc_ov  = 1'b0;
        case (aluop)
            4'd0:  sc_res = portb << shamt;
            4'd1:  sc_res = portb >> shamt;
            4'd2: begin
                sc_res = sum;
                sc_ov  = (porta[WIDTH-1] == portb[WIDTH-1]) && (sum[WIDTH-1] != porta[WIDTH-1]);
            end
            4'd3: begin
                sc_res = dif;
                sc_ov  = (porta[WIDTH-1] != portb[WIDTH-1]) && (dif[WIDTH-1] != porta[WIDTH-1]);
            end
            4'd4:  sc_res = porta & portb;
            4'd5:  sc_res = porta | portb;
            4'd6:  sc_res = porta ^ portb;
            4'd7:  sc_res = ~(porta | portb);
            4'd8:  sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'd9:  sc_res = {{(WIDTH-1){1'b0}}, (porta < portb)};
            4'd10: sc_res = b_s >>> shamt;
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            outport   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (accept) begin
                        op_q <= aluop;
                        a_q  <= porta;
                        b_q  <= portb;
                        if (is_mul) begin
                            acc_q <= '0;
                            cnt   <= CNT_INIT;
                            state <= MUL;
                        end else if (is_div) begin
                            rem_q <= '0;
                            cnt   <= CNT_INIT;
                            state <= DIV;
                        end else begin
                            outport   <= sc_res;
                            overflow  <= sc_ov;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_nx;
                    b_q   <= b_q << 1;
                    cnt   <= cnt - CNT_ONE;
                    if (last) begin
                        outport   <= (op_q == 4'd12) ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DIV: begin
                    rem_q <= rem_nx;
                    a_q   <= quo_nx;
                    cnt   <= cnt - CNT_ONE;
                    if (last) begin
                        outport   <= (op_q == 4'd14) ? rem_nx : quo_nx;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at accept, compared on consume.
module tb_alu_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluop;
    logic [31:0] porta;
    logic [31:0] portb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outport;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .porta(porta), .portb(portb),
        .out_valid(out_valid), .out_ready(out_ready), .outport(outport),
        .negative(negative), .zero(zero), .overflow(overflow), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint s;
        logic [63:0] p;
        logic [31:0] m;
        e.res = '0;
        e.ov  = 1'b0;
        case (op)
            4'd0: e.res = b << a[4:0];
            4'd1: e.res = b >> a[4:0];
            4'd2: begin
                e.res = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                e.res = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: e.res = a & b;
            4'd5: e.res = a | b;
            4'd6: e.res = a ^ b;
            4'd7: e.res = ~(a | b);
            4'd8: e.res = {31'd0, (a[31] & ~b[31]) | ((a[31] == b[31]) & (a < b))};
            4'd9: e.res = {31'd0, a < b};
            4'd10: begin
                m = 32'hFFFF_FFFF >> a[4:0];
                e.res = (b >> a[4:0]) | (b[31] ? ~m : 32'd0);
            end
            4'd11: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
            4'd12: begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; end
            4'd13: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: e.res = (b == 0) ? a : a % b;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Consumer side: compare each consumed result against the oldest expectation
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 64'(outport), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("outport",  64'(outport),  64'(e.res));
                chk("overflow", 64'(overflow), 64'(e.ov));
                chk("negative", 64'(negative), 64'(e.res[31]));
                chk("zero",     64'(zero),     64'(e.res == 0));
            end
        end
    end

    // Called at posedge+1; returns with inputs dropped, at posedge+1 after accept
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int t0, output int waits);
        bit acc = 0;
        waits = 0;
        t0 = 0;
        in_valid = 1'b1;
        aluop = op;
        porta = a;
        portb = b;
        while (!acc && waits < 200) begin
            @(negedge CLK);
            acc = in_ready;
            t0 = cyc;
            @(posedge CLK);
            #1;
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        else sb_q.push_back(model(op, a, b));
    endtask

    task automatic wait_result(input string tag, input int t0, input int exp_lat, output int busy_n);
        bit seen = 0;
        int n = 0;
        busy_n = 0;
        while (!seen && n < 100) begin
            @(negedge CLK);
            if (out_valid) seen = 1;
            else begin
                if (busy) busy_n++;
                n++;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
            chk({tag, "_busy_at_out"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int busy_n);
        int t0, waits;
        @(posedge CLK);
        #1;
        issue(op, a, b, t0, waits);
        wait_result($sformatf("op%0d", op), t0, (op >= 4'd11 && op <= 4'd14) ? 33 : 1, busy_n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_outport"},   64'(outport),   64'd0);
        chk({tag, "_zero"},      64'(zero),      64'd1);
        chk({tag, "_negative"},  64'(negative),  64'd0);
        chk({tag, "_overflow"},  64'(overflow),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int bn, t0, waits, vcnt;
        logic [3:0] op;
        RST = 1'b1;
        in_valid = 1'b0;
        aluop = '0;
        porta = '0;
        portb = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready_after", 64'(in_ready), 64'd1);

        // Directed single-cycle cases
        run(4'd2,  32'h7FFF_FFFF, 32'h1, bn);
        run(4'd10, 32'd4, 32'hF000_0000, bn);
        run(4'd1,  32'd4, 32'hF000_0000, bn);
        run(4'd8,  32'hFFFF_FFFF, 32'd1, bn);
        run(4'd9,  32'hFFFF_FFFF, 32'd1, bn);
        run(4'd3,  32'h8000_0000, 32'd1, bn);
        run(4'd3,  32'd5, 32'd5, bn);
        run(4'd0,  32'd31, 32'h3, bn);
        run(4'd7,  32'h0F0F_0000, 32'h0000_F0F0, bn);
        run(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, bn);

        // Iterative ops
        run(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn);
        chk("mulhi_busy_cycles", 64'(bn), 64'd32);
        run(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn);
        run(4'd13, 32'd100, 32'd7, bn);
        chk("divu_busy_cycles", 64'(bn), 64'd32);
        run(4'd14, 32'd100, 32'd7, bn);
        run(4'd13, 32'd5, 32'd0, bn);
        run(4'd14, 32'd5, 32'd0, bn);

        // Random mix
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            run(op, $urandom, (i % 6 == 5) ? 32'd0 : $urandom >> (i % 4) * 8, bn);
        end

        // Backpressure: result held, no accept, then consume and accept in the same edge
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        issue(4'd2, 32'h8000_0000, 32'h8000_0000, t0, waits);
        wait_result("bp_add", t0, 1, bn);
        for (int i = 0; i < 5; i++) begin
            chk("bp_outport",  64'(outport),   64'd0);
            chk("bp_overflow", 64'(overflow),  64'd1);
            chk("bp_zero",     64'(zero),      64'd1);
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        issue(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, t0, waits);
        chk("bp_same_cycle_accept", 64'(waits), 64'd0);
        wait_result("bp_xor", t0, 1, bn);

        // Reset mid-divide aborts the op
        @(posedge CLK);
        #1;
        issue(4'd13, 32'd1000, 32'd3, t0, waits);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        void'(sb_q.pop_back());
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("abort");
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (out_valid) vcnt++;
        end
        chk("abort_no_result", 64'(vcnt), 64'd0);
        run(4'd2, 32'd2, 32'd3, bn);

        repeat (3) @(posedge CLK);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds valid/ready handshakes on the operand and result sides, registered results and flags, and a new SRA op.
- Adds iterative unsigned multiply (low and high word) and unsigned divide/remainder.
- Sits between decode/issue and writeback in the multicycle and pipelined cores; one operation is outstanding at a time.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4.
- SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.
- CW, $clog2(WIDTH+1), iteration counter width; derived.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- aluop  in  4  operation code, see Behaviour.
- porta  in  WIDTH  operand A; shift amount for shift ops.
- portb  in  WIDTH  operand B; value being shifted for shift ops.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- outport  out  WIDTH  result.
- negative  out  1  outport[WIDTH-1].
- zero  out  1  outport == 0.
- overflow  out  1  signed overflow for ADD and SUB; 0 for all other ops.
- busy  out  1  high while an iterative op is in progress.

Behaviour:
- Op codes:
  - 0 SLL, 1 SRL, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU.
  - 10 SRA: arithmetic shift right of portb by porta[SHW-1:0].
  - 11 MULLO: low WIDTH bits of unsigned A*B.
  - 12 MULHI: high WIDTH bits of unsigned A*B.
  - 13 DIVU: A/B. 14 REMU: A%B.
  - 15: result 0, all flags from that 0 result, latency 1.
- Shift ops use porta[SHW-1:0] only. SLT and SLTU produce a zero-extended 0/1.
- Overflow rules:
  - ADD: operand sign bits equal and result sign differs.
  - SUB: operand sign bits differ and result sign differs from A.
- Handshake:
  - A transfer occurs when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so a new op may be accepted in the same cycle the previous result is consumed.
- FSM states: IDLE, MUL, DIV.
  - IDLE, single-cycle op accepted: result and flags registered; out_valid=1 next cycle (latency 1).
  - IDLE, op 11/12 accepted: latch A and B, clear the 2*WIDTH accumulator, counter=WIDTH, go to MUL.
  - IDLE, op 13/14 accepted: latch A and B, clear the remainder, counter=WIDTH, go to DIV.
  - MUL: one shift-add step per cycle. When the counter reaches 0, register the selected word, assert out_valid, return to IDLE. Latency from accept to out_valid is WIDTH+1 cycles.
  - DIV: one restoring step per cycle. Same completion rule and latency WIDTH+1.
  - busy=1 exactly while in MUL or DIV.
- Divide by zero:
  - DIVU returns all ones; REMU returns A.
  - Same latency as a normal divide (no early exit), so latency is data-independent.
- Result holding:
  - outport and flags are held stable while out_valid && !out_ready.
  - out_valid falls the cycle after consumption unless a new single-cycle result is loaded in that same cycle.
- Inputs are ignored when in_ready=0. Input changes during MUL/DIV have no effect.
- Reset:
  - RST=1 forces IDLE, out_valid=0, outport=0, overflow=0, busy=0, counter=0.
  - zero=1 and negative=0, derived from outport=0.
  - in_ready=1 in the first cycle after RST deasserts.
  - RST mid-MUL or mid-DIV aborts the op and produces no result.
- Flags are always derived from the registered outport, except overflow, which is registered alongside it.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 1, out_ready=1 -> one cycle later out_valid=1, outport=0x80000000, overflow=1, negative=1, zero=0.
- SRA: A=4, B=0xF0000000 -> 0xFF000000. SRL with the same operands -> 0x0F000000. SLT(-1,1)=1; SLTU(-1,1)=0.
- MULHI 0xFFFFFFFF * 0xFFFFFFFF -> out_valid exactly 33 cycles after accept, outport=0xFFFFFFFE, busy=1 for 32 cycles. MULLO with the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Each takes 33 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> outport and flags stable and in_ready=0 throughout. Raise out_ready with in_valid high -> new op accepted in the same cycle as consumption.
- Assert RST for one cycle mid-DIV (cycle 10) -> no out_valid for the aborted op, outputs at reset values, in_ready=1 in the next cycle. A following ADD 2+3 -> 5.
